// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
// Latency: every count/state/expired update is registered, one cycle after the qualifying edge.
// Backpressure: none; tick is a single-cycle enable and every qualified tick is consumed.
//
// Ports:
//   clk         single clock, rising edge
//   reset_n     synchronous active-low reset
//   load        load clamped load_value into count and the reload register, go IDLE
//   load_value  BCD value, digit i at bits [4i+3:4i]; digits above 9 are clamped to 9
//   start       begin counting from IDLE, or resume from PAUSE
//   pause       suspend counting (RUN -> PAUSE)
//   tick        count-enable pulse from the prescaler
//   count       current BCD value
//   running     high while in RUN
//   expired     one-cycle pulse the cycle after the expiring tick
//   zero        combinational count == 0
module bcd_down_counter #(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  expired,
  output logic                  zero
);

  localparam int W = 4 * DIGITS;

  // Value at which the next tick expires the timer: digit 0 = 1, all others 0.
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   reload_val;
  logic [W-1:0]   reload_nxt;
  logic [W-1:0]   count_nxt;
  logic           expired_nxt;
  logic [W-1:0]   load_clamped;

  // Saturate each digit of a raw input to 9 so the counter never holds a non-BCD digit.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  // Ripple-borrow BCD decrement: zero digits become 9 and pass the borrow on,
  // the first nonzero digit absorbs it. Only called with a nonzero argument.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign load_clamped = clamp_bcd(load_value);
  assign zero         = (count == '0);
  assign running      = (state == RUN);

  // Next-state / datapath. Per-cycle priority: load > pause > start > tick.
  // A lower-priority input asserted together with a higher one is dropped for
  // that cycle, so start in RUN swallows a coincident tick and pause in any
  // state blocks a coincident start.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    reload_nxt  = reload_val;
    expired_nxt = 1'b0;

    if (load) begin
      count_nxt  = load_clamped;
      reload_nxt = load_clamped;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Starting at zero would expire immediately with nothing to count.
          if (!pause && start && !zero) begin
            state_nxt = RUN;
          end
        end

        RUN: begin
          if (pause) begin
            state_nxt = PAUSE;
          end else if (start) begin
            state_nxt = RUN;
          end else if (tick && !zero) begin
            if (count == ONE) begin
              expired_nxt = 1'b1;
              if (AUTO_RELOAD) begin
                // Periodic mode: skip the zero value and go straight back to
                // the last loaded value.
                count_nxt = reload_val;
              end else begin
                count_nxt = '0;
                state_nxt = EXPIRED;
              end
            end else begin
              count_nxt = bcd_dec(count);
            end
          end
        end

        PAUSE: begin
          if (!pause && start) begin
            state_nxt = RUN;
          end
        end

        EXPIRED: begin
          // Terminal until load or reset.
          state_nxt = EXPIRED;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_val <= '0;
      expired    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_val <= reload_nxt;
      expired    <= expired_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: one stop-at-zero instance and one auto-reload
// instance share the same stimulus. Directed vector table first, then random
// stimulus against a decimal-arithmetic reference model.
module tb_bcd_down_counter;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic        tick;

  logic [15:0] count_s;
  logic        running_s;
  logic        expired_s;
  logic        zero_s;
  logic [15:0] count_r;
  logic        running_r;
  logic        expired_r;
  logic        zero_r;

  int vectors;
  int miscompares;

  bcd_down_counter #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut_stop (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .tick(tick),
    .count(count_s), .running(running_s), .expired(expired_s), .zero(zero_s)
  );

  bcd_down_counter #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut_reload (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .tick(tick),
    .count(count_r), .running(running_r), .expired(expired_r), .zero(zero_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        ld;
    logic [15:0] lv;
    logic        st;
    logic        ps;
    logic        tk;
    logic [15:0] cnt_s;
    logic        run_s;
    logic        exp_s;
    logic [15:0] cnt_r;
    logic        run_r;
    logic        exp_r;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, input logic ld, input logic [15:0] lv,
                     input logic st, input logic ps, input logic tk,
                     input logic [15:0] cs, input logic rs, input logic es,
                     input logic [15:0] cr, input logic rr, input logic er);
    vec_t v;
    v.rst_n = rst_n; v.ld = ld; v.lv = lv; v.st = st; v.ps = ps; v.tk = tk;
    v.cnt_s = cs; v.run_s = rs; v.exp_s = es;
    v.cnt_r = cr; v.run_r = rr; v.exp_r = er;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model (decimal integers) ----------------
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  int m_val[2];
  int m_rel[2];
  int m_st[2];
  bit m_exp[2];

  function automatic int clamp_val(input logic [15:0] lv);
    int r, p, d;
    logic [15:0] t;
    r = 0; p = 1; t = lv;
    for (int i = 0; i < 4; i++) begin
      d = int'(t[3:0]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
      t = t >> 4;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0; t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int k);
    m_exp[k] = 1'b0;
    if (!reset_n) begin
      m_val[k] = 0; m_rel[k] = 0; m_st[k] = S_IDLE;
    end else if (load) begin
      m_val[k] = clamp_val(load_value); m_rel[k] = m_val[k]; m_st[k] = S_IDLE;
    end else begin
      case (m_st[k])
        S_IDLE:  if (!pause && start && m_val[k] != 0) m_st[k] = S_RUN;
        S_RUN: begin
          if (pause) m_st[k] = S_PAUSE;
          else if (!start && tick && m_val[k] > 0) begin
            if (m_val[k] == 1) begin
              m_exp[k] = 1'b1;
              if (k == 1) m_val[k] = m_rel[k];
              else begin m_val[k] = 0; m_st[k] = S_EXP; end
            end else begin
              m_val[k] = m_val[k] - 1;
            end
          end
        end
        S_PAUSE: if (!pause && start) m_st[k] = S_RUN;
        default: ;
      endcase
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;

    //   rst ld  lv        st ps tk   cnt_s   rs es   cnt_r   rr er
    add(0, 1, 16'h1234, 1, 0, 1,  16'h0000,0,0,  16'h0000,0,0); // reset beats everything
    add(1, 1, 16'h1000, 0, 0, 0,  16'h1000,0,0,  16'h1000,0,0);
    add(1, 0, 16'h0000, 1, 0, 1,  16'h1000,1,0,  16'h1000,1,0); // tick with start not counted
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0999,1,0,  16'h0999,1,0); // borrow chain
    add(1, 1, 16'h0100, 0, 0, 0,  16'h0100,0,0,  16'h0100,0,0);
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0100,1,0,  16'h0100,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0099,1,0,  16'h0099,1,0);
    add(1, 1, 16'h0003, 0, 0, 0,  16'h0003,0,0,  16'h0003,0,0); // expiry
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0003,1,0,  16'h0003,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0002,1,0,  16'h0002,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0001,1,0,  16'h0001,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0000,0,1,  16'h0003,1,1);
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0000,0,0,  16'h0003,1,0); // EXPIRED ignores start
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0000,0,0,  16'h0002,1,0);
    add(1, 1, 16'h0002, 0, 0, 0,  16'h0002,0,0,  16'h0002,0,0); // auto-reload sequence
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0002,1,0,  16'h0002,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0001,1,0,  16'h0001,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0000,0,1,  16'h0002,1,1);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0000,0,0,  16'h0001,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0000,0,0,  16'h0002,1,1);
    add(1, 1, 16'h0050, 0, 0, 0,  16'h0050,0,0,  16'h0050,0,0); // pause / priority
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0050,1,0,  16'h0050,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0049,1,0,  16'h0049,1,0);
    add(1, 0, 16'h0000, 0, 1, 1,  16'h0049,0,0,  16'h0049,0,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0049,0,0,  16'h0049,0,0);
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0049,1,0,  16'h0049,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h0048,1,0,  16'h0048,1,0);
    add(1, 1, 16'h0000, 0, 0, 0,  16'h0000,0,0,  16'h0000,0,0); // start at zero blocked
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0000,0,0,  16'h0000,0,0);
    add(1, 0, 16'h0000, 1, 0, 1,  16'h0000,0,0,  16'h0000,0,0);
    add(1, 1, 16'hAF3C, 0, 0, 0,  16'h9939,0,0,  16'h9939,0,0); // clamp
    add(1, 1, 16'h0001, 0, 0, 0,  16'h0001,0,0,  16'h0001,0,0);
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0001,1,0,  16'h0001,1,0);
    add(1, 1, 16'h0007, 0, 0, 1,  16'h0007,0,0,  16'h0007,0,0); // load beats expiring tick
    add(1, 0, 16'h0000, 1, 0, 0,  16'h0007,1,0,  16'h0007,1,0);
    add(1, 0, 16'h0000, 1, 0, 1,  16'h0007,1,0,  16'h0007,1,0); // start in RUN drops tick
    add(0, 0, 16'h0000, 1, 0, 1,  16'h0000,0,0,  16'h0000,0,0); // reset mid-count
    add(1, 0, 16'h0000, 1, 0, 1,  16'h0000,0,0,  16'h0000,0,0);
    add(1, 1, 16'h2000, 0, 0, 0,  16'h2000,0,0,  16'h2000,0,0);
    add(1, 0, 16'h0000, 1, 0, 0,  16'h2000,1,0,  16'h2000,1,0);
    add(1, 0, 16'h0000, 0, 0, 1,  16'h1999,1,0,  16'h1999,1,0);

    foreach (tbl[i]) begin
      reset_n = tbl[i].rst_n; load = tbl[i].ld; load_value = tbl[i].lv;
      start = tbl[i].st; pause = tbl[i].ps; tick = tbl[i].tk;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d count_s", i),   32'(count_s),   32'(tbl[i].cnt_s));
      chk($sformatf("tbl%0d running_s", i), 32'(running_s), 32'(tbl[i].run_s));
      chk($sformatf("tbl%0d expired_s", i), 32'(expired_s), 32'(tbl[i].exp_s));
      chk($sformatf("tbl%0d zero_s", i),    32'(zero_s),    32'(tbl[i].cnt_s == 16'h0000));
      chk($sformatf("tbl%0d count_r", i),   32'(count_r),   32'(tbl[i].cnt_r));
      chk($sformatf("tbl%0d running_r", i), 32'(running_r), 32'(tbl[i].run_r));
      chk($sformatf("tbl%0d expired_r", i), 32'(expired_r), 32'(tbl[i].exp_r));
      chk($sformatf("tbl%0d zero_r", i),    32'(zero_r),    32'(tbl[i].cnt_r == 16'h0000));
    end

    // Random phase: last table row ends with both DUTs mid-count, so start
    // from a reset cycle to put model and DUTs in a known common state.
    for (int n = 0; n < 3000; n++) begin
      reset_n = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      load    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) != 0) load_value = 16'($urandom_range(0, 65535));
      else                           load_value = to_bcd($urandom_range(0, 12));
      start   = ($urandom_range(0, 7) == 0);
      pause   = ($urandom_range(0, 15) == 0);
      tick    = ($urandom_range(0, 1) != 0);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d count_s", n),   32'(count_s),   32'(to_bcd(m_val[0])));
      chk($sformatf("rnd%0d running_s", n), 32'(running_s), 32'(m_st[0] == S_RUN));
      chk($sformatf("rnd%0d expired_s", n), 32'(expired_s), 32'(m_exp[0]));
      chk($sformatf("rnd%0d zero_s", n),    32'(zero_s),    32'(m_val[0] == 0));
      chk($sformatf("rnd%0d count_r", n),   32'(count_r),   32'(to_bcd(m_val[1])));
      chk($sformatf("rnd%0d running_r", n), 32'(running_r), 32'(m_st[1] == S_RUN));
      chk($sformatf("rnd%0d expired_r", n), 32'(expired_r), 32'(m_exp[1]));
      chk($sformatf("rnd%0d zero_r", n),    32'(zero_r),    32'(m_val[1] == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
